// File: rtl/formal_cmp_sequencer.sv
// formal_cmp_sequencer
//   On-chip replacement for the random formal-compare testbench. It drives a shared
//   pseudo-random reset/enable stimulus into the fabric and the benchmark from an LFSR.
//   It waits out a skip window, then compares the two output buses for a fixed window,
//   and finally reports a pass/fail verdict.
//
//   Ports
//     clk            single clock, rising edge
//     reset          asynchronous, active-low
//     start          one-cycle run request, honoured only in IDLE/DONE
//     stim_reset     shared reset stimulus (registered)
//     stim_enable    shared enable stimulus (registered)
//     fpga_out       fabric outputs
//     bench_out      benchmark outputs
//     bench_xmask    1 = benchmark bit unknown, excluded from the compare
//     busy           high in SKIP or RUN
//     done           high in DONE until the next start or reset
//     pass           verdict, valid while done=1
//     nb_error       saturating count of mismatch events (per-bit 0->1 rises)
//     err_bitmap     sticky OR of every bit that mismatched this run
//     first_err_cyc  RUN cycle index of the first mismatch, 8'hFF if none
//
//   state | meaning
//   IDLE  | waiting for start after reset, stimulus held at 0
//   SKIP  | stimulus running, compare disabled (initialisation edge)
//   RUN   | stimulus running, mismatches counted
//   DONE  | verdict held, stimulus at 0, start begins a fresh run
module formal_cmp_sequencer #(
    parameter int          WIDTH       = 16,
    parameter int          SKIP_CYCLES = 1,
    parameter int          RUN_CYCLES  = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             stim_reset,
    output logic             stim_enable,
    input  logic [WIDTH-1:0] fpga_out,
    input  logic [WIDTH-1:0] bench_out,
    input  logic [WIDTH-1:0] bench_xmask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] nb_error,
    output logic [WIDTH-1:0] err_bitmap,
    output logic [7:0]       first_err_cyc
);

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    localparam int SKW  = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
    localparam int PCW  = $clog2(WIDTH + 1);
    localparam int SUMW = ERR_W + PCW;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
    localparam logic [7:0]     RUN_LAST  = 8'(RUN_CYCLES - 1);

    state_t           state, state_d;
    logic [SKW-1:0]   skip_cnt, skip_cnt_d;
    logic [7:0]       run_cnt, run_cnt_d;
    logic [15:0]      lfsr, lfsr_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [WIDTH-1:0] mis, rise, err_bitmap_d;
    logic [ERR_W-1:0] nb_error_d;
    logic [7:0]       first_err_cyc_d;
    logic [PCW-1:0]   rise_cnt;
    logic [SUMW-1:0]  sum;
    logic             start_ok, pass_d, busy_d;

    assign busy = (state == SKIP) || (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_d    = state;
        skip_cnt_d = skip_cnt;
        run_cnt_d  = run_cnt;
        start_ok   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    skip_cnt_d = '0;
                    run_cnt_d  = '0;
                    state_d    = (SKIP_CYCLES == 0) ? RUN : SKIP;
                end
            end
            SKIP: begin
                if (skip_cnt == SKIP_LAST) state_d = RUN;
                else                       skip_cnt_d = skip_cnt + 1'b1;
            end
            RUN: begin
                if (run_cnt == RUN_LAST) state_d = DONE;
                else                     run_cnt_d = run_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mis      = (fpga_out ^ bench_out) & ~bench_xmask;
        rise     = mis & ~flag_q;
        rise_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_cnt = rise_cnt + PCW'(rise[i]);
        end
        sum = SUMW'(nb_error) + SUMW'(rise_cnt);

        lfsr_d          = lfsr;
        flag_d          = '0;
        nb_error_d      = nb_error;
        err_bitmap_d    = err_bitmap;
        first_err_cyc_d = first_err_cyc;
        pass_d          = pass;
        busy_d          = (state_d == SKIP) || (state_d == RUN);

        if (start_ok) begin
            lfsr_d          = LFSR_SEED;
            nb_error_d      = '0;
            err_bitmap_d    = '0;
            first_err_cyc_d = 8'hFF;
            pass_d          = 1'b0;
        end else if (busy) begin
            // Galois right-shift form of polynomial 0xB400
            lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end

        if (state == RUN) begin
            flag_d = mis;
            // several bits may rise together, so clamp the widened sum
            if (sum > SUMW'({ERR_W{1'b1}})) nb_error_d = '1;
            else                             nb_error_d = ERR_W'(sum);
            err_bitmap_d = err_bitmap | mis;
            if ((mis != '0) && (first_err_cyc == 8'hFF)) first_err_cyc_d = run_cnt;
            // verdict must include the count update made on this same edge
            if (state_d == DONE) pass_d = (nb_error_d == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            skip_cnt      <= '0;
            run_cnt       <= '0;
            lfsr          <= LFSR_SEED;
            flag_q        <= '0;
            nb_error      <= '0;
            err_bitmap    <= '0;
            first_err_cyc <= 8'hFF;
            pass          <= 1'b0;
            stim_reset    <= 1'b0;
            stim_enable   <= 1'b0;
        end else begin
            state         <= state_d;
            skip_cnt      <= skip_cnt_d;
            run_cnt       <= run_cnt_d;
            lfsr          <= lfsr_d;
            flag_q        <= flag_d;
            nb_error      <= nb_error_d;
            err_bitmap    <= err_bitmap_d;
            first_err_cyc <= first_err_cyc_d;
            pass          <= pass_d;
            // stimulus follows the LFSR word held during each busy cycle
            stim_reset    <= busy_d & lfsr_d[0];
            stim_enable   <= busy_d & lfsr_d[1];
        end
    end

endmodule

// File: tb/tb_formal_cmp_sequencer.sv
module tb_formal_cmp_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] fpga_out = '0;
    logic [15:0] bench_out = '0;
    logic [15:0] bench_xmask = '0;

    logic        stim_reset, stim_enable, busy, done, pass;
    logic [15:0] nb_error, err_bitmap;
    logic [7:0]  first_err_cyc;

    logic        s_stim_reset, s_stim_enable, s_busy, s_done, s_pass;
    logic [3:0]  s_nb_error;
    logic [15:0] s_err_bitmap;
    logic [7:0]  s_first_err_cyc;

    always #5 clk = ~clk;

    formal_cmp_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .stim_reset(stim_reset), .stim_enable(stim_enable),
        .fpga_out(fpga_out), .bench_out(bench_out), .bench_xmask(bench_xmask),
        .busy(busy), .done(done), .pass(pass),
        .nb_error(nb_error), .err_bitmap(err_bitmap), .first_err_cyc(first_err_cyc)
    );

    formal_cmp_sequencer #(.ERR_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start),
        .stim_reset(s_stim_reset), .stim_enable(s_stim_enable),
        .fpga_out(fpga_out), .bench_out(bench_out), .bench_xmask(bench_xmask),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .nb_error(s_nb_error), .err_bitmap(s_err_bitmap), .first_err_cyc(s_first_err_cyc)
    );

    typedef struct {
        logic        pass;
        int          nb;
        logic [15:0] bm;
        logic [7:0]  fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // monitor: captures the stimulus of each busy window and scores every verdict
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int          bcnt = 0;
    logic [31:0] sr_v, se_v, exp_sr, exp_se;
    logic [15:0] lm;
    exp_t        e;

    always @(negedge clk) begin
        if (busy) begin
            if (!prev_busy) begin
                bcnt = 0;
                sr_v = '0;
                se_v = '0;
            end
            if (bcnt < 32) begin
                sr_v[bcnt] = stim_reset;
                se_v[bcnt] = stim_enable;
            end
            bcnt++;
        end
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done rose, no verdict expected");
            end else begin
                e = exp_q.pop_front();
                check("busy_len", bcnt, 11);
                check("pass", pass, e.pass);
                check("nb_error", nb_error, e.nb);
                check("err_bitmap", err_bitmap, e.bm);
                check("first_err_cyc", first_err_cyc, e.fe);
                check("nb_error_sat4", s_nb_error, (e.nb > 15) ? 15 : e.nb);
                check("stim_off_in_done", {stim_reset, stim_enable}, 2'b00);
                exp_sr = '0;
                exp_se = '0;
                lm = 16'hACE1;
                for (int k = 0; k < 11; k++) begin
                    exp_sr[k] = lm[0];
                    exp_se[k] = lm[1];
                    lm = galois(lm);
                end
                check("stim_reset_seq", sr_v, exp_sr);
                check("stim_enable_seq", se_v, exp_se);
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic do_run(input logic [9:0][15:0] f, input logic [15:0] xm, input bit poke_start,
                          input int nb, input logic [15:0] bm, input logic [7:0] fe);
        exp_t x;
        x.pass = (nb == 0);
        x.nb = nb;
        x.bm = bm;
        x.fe = fe;
        exp_q.push_back(x);
        bench_xmask = xm;
        @(negedge clk);
        start = 1'b1;
        fpga_out = bench_out;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            bench_out = 16'h5A3C ^ 16'(r * 16'h0931);
            fpga_out = bench_out ^ f[r];
            start = poke_start && (r == 4);
        end
        @(negedge clk);
        start = 1'b0;
        fpga_out = bench_out;
        bench_xmask = '0;
        repeat (2) @(negedge clk);
    endtask

    logic [9:0][15:0] f;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_nb_error", nb_error, 0);
        check("rst_err_bitmap", err_bitmap, 0);
        check("rst_first_err_cyc", first_err_cyc, 8'hFF);
        check("rst_stim", {stim_reset, stim_enable}, 2'b00);
        reset = 1'b1;
        @(negedge clk);

        f = '0;
        do_run(f, 16'h0000, 1'b0, 0, 16'h0000, 8'hFF);
        check("done_hold", done, 1'b1);

        f = '0;
        for (int r = 0; r < 10; r++) f[r] = 16'h0008;
        do_run(f, 16'h0000, 1'b0, 1, 16'h0008, 8'd0);

        f = '0;
        f[2] = 16'h0001;
        f[3] = 16'h0001;
        f[5] = 16'h0001;
        do_run(f, 16'h0000, 1'b0, 2, 16'h0001, 8'd2);
        do_run(f, 16'h0001, 1'b0, 0, 16'h0000, 8'hFF);

        f = '0;
        f[0] = 16'hFFFF;
        f[2] = 16'hFFFF;
        do_run(f, 16'h0000, 1'b0, 32, 16'hFFFF, 8'd0);

        f = '0;
        f[6] = 16'h0002;
        f[7] = 16'h0082;
        f[9] = 16'h0080;
        do_run(f, 16'h0000, 1'b0, 3, 16'h0082, 8'd6);

        f = '0;
        do_run(f, 16'h0000, 1'b0, 0, 16'h0000, 8'hFF);
        do_run(f, 16'h0000, 1'b1, 0, 16'h0000, 8'hFF);

        // reset asserted in the middle of RUN cycle 4 after a fault in RUN cycle 1
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            fpga_out = bench_out ^ ((r == 1) ? 16'h0010 : 16'h0000);
        end
        check("midrun_nb_error", nb_error, 1);
        check("midrun_first_err_cyc", first_err_cyc, 8'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_nb_error", nb_error, 0);
        check("midrst_err_bitmap", err_bitmap, 0);
        check("midrst_first_err_cyc", first_err_cyc, 8'hFF);
        check("midrst_stim", {stim_reset, stim_enable}, 2'b00);
        @(negedge clk);
        fpga_out = bench_out;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_idle_busy", busy, 1'b0);

        // start while reset is held low must not launch a run
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("start_in_reset_busy", busy, 1'b0);
        check("start_in_reset_done", done, 1'b0);

        f = '0;
        do_run(f, 16'h0000, 1'b0, 0, 16'h0000, 8'hFF);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
